// File: rtl/arith_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_issue_pkg
// Description : Shared constants and types for the arith_issue_stage slice.
//               Holds the DLX opcode/func codes, the alu_arith select vector
//               type with one named constant per operation, and the packed
//               pipeline entry carried through the main/skid registers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package arith_issue_pkg;

   localparam int DATA_W = 32;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDUI = 6'h09;
   localparam logic [5:0] OP_SUBI  = 6'h0A;
   localparam logic [5:0] OP_SUBUI = 6'h0B;
   localparam logic [5:0] OP_SEQI  = 6'h18;
   localparam logic [5:0] OP_SNEI  = 6'h19;
   localparam logic [5:0] OP_SLTI  = 6'h1A;
   localparam logic [5:0] OP_SGTI  = 6'h1B;
   localparam logic [5:0] OP_SLEI  = 6'h1C;
   localparam logic [5:0] OP_SGEI  = 6'h1D;

   // R-type func codes
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_SEQ  = 6'h28;
   localparam logic [5:0] FN_SNE  = 6'h29;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SGT  = 6'h2B;
   localparam logic [5:0] FN_SLE  = 6'h2C;
   localparam logic [5:0] FN_SGE  = 6'h2D;

   // Select vector, bit order {sel0,sel1,sel2,sel3,sel4}: sel[4] is sel0.
   typedef logic [4:0] sel_t;

   localparam sel_t SEL_ADD = 5'b00000;
   localparam sel_t SEL_SUB = 5'b00011;
   localparam sel_t SEL_SEQ = 5'b00001;
   localparam sel_t SEL_SNE = 5'b10001;
   localparam sel_t SEL_SLT = 5'b01001;
   localparam sel_t SEL_SGT = 5'b11001;
   localparam sel_t SEL_SLE = 5'b00101;
   localparam sel_t SEL_SGE = 5'b01101;

   typedef struct packed {
      logic [DATA_W-1:0] in1;
      logic [DATA_W-1:0] in2;
      sel_t              sel;
      logic [4:0]        rd;
      logic              illegal;
   } entry_t;

endpackage
`default_nettype wire

// File: rtl/arith_issue_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : arith_issue_stage_if
// Description : Handshake and data bundle between ID, the issue stage and EX.
//               slave  : view of the issue stage itself.
//               master : view of the surrounding pipeline (ID driver + EX sink).
// Ports       : flush, in_valid/in_ready, instr, rs1_data, rs2_data,
//               out_valid/out_ready, alu_in1, alu_in2, sel0..sel4, rd, illegal
// Revision    : 1.0 - initial release
// ============================================================================
interface arith_issue_stage_if #(
   parameter int DATA_W = 32
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       instr;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] alu_in1;
   logic [DATA_W-1:0] alu_in2;
   logic              sel0;
   logic              sel1;
   logic              sel2;
   logic              sel3;
   logic              sel4;
   logic [4:0]        rd;
   logic              illegal;

   modport slave (
      input  flush, in_valid, instr, rs1_data, rs2_data, out_ready,
      output in_ready, out_valid, alu_in1, alu_in2,
             sel0, sel1, sel2, sel3, sel4, rd, illegal
   );

   modport master (
      output flush, in_valid, instr, rs1_data, rs2_data, out_ready,
      input  in_ready, out_valid, alu_in1, alu_in2,
             sel0, sel1, sel2, sel3, sel4, rd, illegal
   );
endinterface
`default_nettype wire

// File: rtl/arith_decode.sv
`default_nettype none
// ============================================================================
// Module      : arith_decode
// Description : Combinational decoder from a DLX arithmetic/compare
//               instruction plus register read values to a pipeline entry.
//               Unsupported encodings yield an all-zero entry flagged illegal.
// Ports       : instr    (in)  instruction word
//               rs1_data (in)  value of instr[25:21]
//               rs2_data (in)  value of instr[20:16]
//               entry    (out) decoded entry
// Revision    : 1.0 - initial release
// ============================================================================
module arith_decode
   import arith_issue_pkg::*;
(
   input  logic [31:0]       instr,
   input  logic [DATA_W-1:0] rs1_data,
   input  logic [DATA_W-1:0] rs2_data,
   output entry_t            entry
);

   logic [5:0] opcode;
   logic [5:0] func;
   logic [15:0] imm;
   logic       legal;
   logic       is_imm;
   logic       zext;
   sel_t       sel;

   // The rs field is already resolved into rs1_data by the register file.
   logic unused_rs_field;
   assign unused_rs_field = ^instr[25:21];

   assign opcode = instr[31:26];
   assign func   = instr[5:0];
   assign imm    = instr[15:0];

   always_comb begin
      legal  = 1'b1;
      is_imm = 1'b1;
      zext   = 1'b0;
      sel    = SEL_ADD;
      if (opcode == OP_RTYPE) begin
         is_imm = 1'b0;
         case (func)
            FN_ADD, FN_ADDU: sel = SEL_ADD;
            FN_SUB, FN_SUBU: sel = SEL_SUB;
            FN_SEQ:          sel = SEL_SEQ;
            FN_SNE:          sel = SEL_SNE;
            FN_SLT:          sel = SEL_SLT;
            FN_SGT:          sel = SEL_SGT;
            FN_SLE:          sel = SEL_SLE;
            FN_SGE:          sel = SEL_SGE;
            default:         legal = 1'b0;
         endcase
      end else begin
         case (opcode)
            OP_ADDI:  sel = SEL_ADD;
            OP_ADDUI: begin sel = SEL_ADD; zext = 1'b1; end
            OP_SUBI:  sel = SEL_SUB;
            OP_SUBUI: begin sel = SEL_SUB; zext = 1'b1; end
            OP_SEQI:  sel = SEL_SEQ;
            OP_SNEI:  sel = SEL_SNE;
            OP_SLTI:  sel = SEL_SLT;
            OP_SGTI:  sel = SEL_SGT;
            OP_SLEI:  sel = SEL_SLE;
            OP_SGEI:  sel = SEL_SGE;
            default:  legal = 1'b0;
         endcase
      end
   end

   always_comb begin
      entry = '0;
      if (legal) begin
         entry.in1 = rs1_data;
         entry.sel = sel;
         if (is_imm) begin
            entry.in2 = zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
            entry.rd  = instr[20:16];
         end else begin
            entry.in2 = rs2_data;
            entry.rd  = instr[15:11];
         end
      end else begin
         entry.illegal = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/arith_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : arith_issue_stage
// Description : Issue stage in front of alu_arith. Decodes the incoming
//               instruction and holds it in a main register (M) that drives
//               the outputs, with a skid register (S) so in_ready can be a
//               flop and EX back-pressure never reaches ID combinationally.
// Ports       : clk   (in) rising-edge clock
//               reset (in) asynchronous active-high reset
//               bus   (slave modport of arith_issue_stage_if) handshake/data
// Revision    : 1.0 - initial release
// ============================================================================
module arith_issue_stage
   import arith_issue_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   arith_issue_stage_if.slave  bus
);

   entry_t dec_w;
   entry_t m_q, m_d;
   entry_t s_q, s_d;
   logic   m_valid_q, m_valid_d;
   logic   s_valid_q, s_valid_d;
   logic   in_ready_q, in_ready_d;
   logic   accept;
   logic   m_free;

   arith_decode u_decode (
      .instr    (bus.instr),
      .rs1_data (bus.rs1_data),
      .rs2_data (bus.rs2_data),
      .entry    (dec_w)
   );

   assign accept = bus.in_valid & in_ready_q;
   // M can take a new entry when it is empty or being consumed this cycle.
   assign m_free = ~m_valid_q | bus.out_ready;

   always_comb begin
      m_d       = m_q;
      s_d       = s_q;
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;
      if (bus.flush) begin
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (m_free) begin
         if (s_valid_q) begin
            // S refills M; in_ready was low so no accept can collide here.
            m_d       = s_q;
            m_valid_d = 1'b1;
            s_valid_d = accept;
            if (accept) s_d = dec_w;
         end else begin
            m_valid_d = accept;
            if (accept) m_d = dec_w;
         end
      end else if (accept) begin
         s_valid_d = 1'b1;
         s_d       = dec_w;
      end
      in_ready_d = ~s_valid_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q        <= '0;
         s_q        <= '0;
         m_valid_q  <= 1'b0;
         s_valid_q  <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         m_q        <= m_d;
         s_q        <= s_d;
         m_valid_q  <= m_valid_d;
         s_valid_q  <= s_valid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = m_valid_q;
   assign bus.alu_in1   = DATA_W'(m_q.in1);
   assign bus.alu_in2   = DATA_W'(m_q.in2);
   assign bus.sel0      = m_q.sel[4];
   assign bus.sel1      = m_q.sel[3];
   assign bus.sel2      = m_q.sel[2];
   assign bus.sel3      = m_q.sel[1];
   assign bus.sel4      = m_q.sel[0];
   assign bus.rd        = m_q.rd;
   assign bus.illegal   = m_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_arith_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_arith_issue_stage
// Description : Self-checking bench for arith_issue_stage. A queue holds the
//               entries the stage should currently contain (head = output);
//               expected entries come from a table-driven instruction model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_issue_stage;

   typedef struct {
      logic [31:0] in1;
      logic [31:0] in2;
      logic [4:0]  sel;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   // sel per operation class: ADD, SUB, SEQ, SNE, SLT, SGT, SLE, SGE
   localparam logic [4:0] SEL_TAB [8] = '{5'b00000, 5'b00011, 5'b00001, 5'b10001,
                                          5'b01001, 5'b11001, 5'b00101, 5'b01101};

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   exp_t q[$];

   arith_issue_stage_if #(.DATA_W(32)) bus ();

   arith_issue_stage #(.DATA_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] r1,
                                       input logic [31:0] r2);
      exp_t e;
      int kind;
      bit imm, zx;
      logic [5:0] op, f;
      op = ins[31:26];
      f  = ins[5:0];
      e.in1 = 0; e.in2 = 0; e.sel = 0; e.rd = 0; e.ill = 1'b1;
      kind = -1; imm = 0; zx = 0;
      if (op == 6'h00) begin
         if (f >= 6'h20 && f <= 6'h23) kind = int'(f[1]);
         else if (f >= 6'h28 && f <= 6'h2D) kind = 2 + int'(f - 6'h28);
      end else if (op >= 6'h08 && op <= 6'h0B) begin
         kind = int'(op[1]); imm = 1; zx = op[0];
      end else if (op >= 6'h18 && op <= 6'h1D) begin
         kind = 2 + int'(op - 6'h18); imm = 1;
      end
      if (kind >= 0) begin
         e.ill = 1'b0;
         e.in1 = r1;
         e.sel = SEL_TAB[kind];
         if (imm) begin
            e.rd  = ins[20:16];
            e.in2 = zx ? {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
         end else begin
            e.rd  = ins[15:11];
            e.in2 = r2;
         end
      end
      return e;
   endfunction

   function automatic logic [31:0] mk_r(input logic [4:0] rs, rt, rdd, input logic [5:0] fn);
      return {6'h00, rs, rt, rdd, 5'h00, fn};
   endfunction

   function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [4:0] dut_sel();
      return {bus.sel0, bus.sel1, bus.sel2, bus.sel3, bus.sel4};
   endfunction

   task automatic compare_model();
      check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      check("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
         check("alu_in1", bus.alu_in1, q[0].in1);
         check("alu_in2", bus.alu_in2, q[0].in2);
         check("sel", 32'(dut_sel()), 32'(q[0].sel));
         check("rd", 32'(bus.rd), 32'(q[0].rd));
         check("illegal", 32'(bus.illegal), 32'(q[0].ill));
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                        input logic [31:0] r2, input logic ordy, input logic fl);
      bit acc;
      bus.in_valid  = v;
      bus.instr     = ins;
      bus.rs1_data  = r1;
      bus.rs2_data  = r2;
      bus.out_ready = ordy;
      bus.flush     = fl;
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else begin
         acc = v && (q.size() < 2);
         if (q.size() > 0 && ordy) void'(q.pop_front());
         if (acc) q.push_back(ref_decode(ins, r1, r2));
      end
      #1;
      compare_model();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] rfn [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D};
      logic [5:0] iop [10] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D};
      int sel;
      logic [31:0] w;
      w = $urandom;
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      return {6'h00, w[25:6], rfn[$urandom_range(0, 9)]};
      else if (sel < 8) return {iop[$urandom_range(0, 9)], w[25:0]};
      else              return w;
   endfunction

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      bus.flush = 0; bus.in_valid = 0; bus.instr = 0;
      bus.rs1_data = 0; bus.rs2_data = 0; bus.out_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_in1", bus.alu_in1, 32'd0);
      check("rst_in2", bus.alu_in2, 32'd0);
      check("rst_sel", 32'(dut_sel()), 32'd0);
      check("rst_rd_ill", {26'd0, bus.rd, bus.illegal}, 32'd0);
      reset = 1'b0;

      // ADD r3,r1,r2
      cycle(1'b1, 32'h0022_1820, 32'd5, 32'd7, 1'b1, 1'b0);
      check("add_valid", 32'(bus.out_valid), 32'd1);
      check("add_in1", bus.alu_in1, 32'd5);
      check("add_in2", bus.alu_in2, 32'd7);
      check("add_sel", 32'(dut_sel()), 32'b00000);
      check("add_rd", 32'(bus.rd), 32'd3);

      // SLTI r4,r1,-1 then ADDUI with imm 0xFFFF
      cycle(1'b1, 32'h6824_FFFF, 32'd9, 32'd0, 1'b1, 1'b0);
      check("slti_in2", bus.alu_in2, 32'hFFFF_FFFF);
      check("slti_sel", 32'(dut_sel()), 32'b01001);
      check("slti_rd", 32'(bus.rd), 32'd4);
      cycle(1'b1, mk_i(6'h09, 5'd1, 5'd6, 16'hFFFF), 32'd1, 32'd0, 1'b1, 1'b0);
      check("addui_in2", bus.alu_in2, 32'h0000_FFFF);

      // Back-to-back compare stream
      begin
         logic [5:0] fns [6] = '{6'h28, 6'h29, 6'h2B, 6'h2C, 6'h2D, 6'h22};
         logic [4:0] sels [6] = '{5'b00001, 5'b10001, 5'b11001, 5'b00101, 5'b01101, 5'b00011};
         for (int i = 0; i < 6; i++) begin
            cycle(1'b1, mk_r(5'd2, 5'd3, 5'(i + 8), fns[i]), 32'(i), 32'(i * 3), 1'b1, 1'b0);
            check("stream_valid", 32'(bus.out_valid), 32'd1);
            check("stream_sel", 32'(dut_sel()), 32'(sels[i]));
         end
      end
      idle(1);

      // Back-pressure: three offers, two absorbed
      cycle(1'b1, mk_r(5'd1, 5'd2, 5'd10, 6'h20), 32'd100, 32'd1, 1'b0, 1'b0);
      check("bp1_in_ready", 32'(bus.in_ready), 32'd1);
      cycle(1'b1, mk_r(5'd1, 5'd2, 5'd11, 6'h22), 32'd200, 32'd2, 1'b0, 1'b0);
      check("bp2_in_ready", 32'(bus.in_ready), 32'd0);
      cycle(1'b1, mk_r(5'd1, 5'd2, 5'd12, 6'h28), 32'd300, 32'd3, 1'b0, 1'b0);
      check("bp3_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp3_head_rd", 32'(bus.rd), 32'd10);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
      check("bp_release_rd", 32'(bus.rd), 32'd11);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("bp_drained", 32'(bus.out_valid), 32'd0);

      // Unsupported opcode
      cycle(1'b1, 32'hFC22_1820, 32'd5, 32'd7, 1'b1, 1'b0);
      check("ill_flag", 32'(bus.illegal), 32'd1);
      check("ill_sel", 32'(dut_sel()), 32'd0);
      check("ill_rd", 32'(bus.rd), 32'd0);

      // Flush with M and S full and a same-cycle offer
      cycle(1'b1, mk_r(5'd1, 5'd2, 5'd13, 6'h20), 32'd1, 32'd1, 1'b0, 1'b0);
      cycle(1'b1, mk_r(5'd1, 5'd2, 5'd14, 6'h20), 32'd2, 32'd2, 1'b0, 1'b0);
      cycle(1'b1, mk_r(5'd1, 5'd2, 5'd15, 6'h20), 32'd3, 32'd3, 1'b0, 1'b1);
      check("flush_out_valid", 32'(bus.out_valid), 32'd0);
      check("flush_in_ready", 32'(bus.in_ready), 32'd1);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom,
               $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);

      // Reset in the middle of a full stage, checked before the next edge
      cycle(1'b1, mk_r(5'd1, 5'd2, 5'd20, 6'h2A), 32'd7, 32'd8, 1'b0, 1'b0);
      cycle(1'b1, mk_r(5'd1, 5'd2, 5'd21, 6'h2B), 32'd7, 32'd8, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      q.delete();
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      check("midrst_in1", bus.alu_in1, 32'd0);
      check("midrst_sel_rd", {22'd0, dut_sel(), bus.rd}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      cycle(1'b1, 32'h0022_1820, 32'd11, 32'd22, 1'b1, 1'b0);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
